// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter: FSM state encoding,
// master IDs and a small ID-to-grant helper.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic [1:0] id_to_onehot(input logic id);
    return (id == M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Arbitration decision for ram_arb. Define RAM_ARB_RR_EN for round-robin;
// the default build uses fixed priority with m1 (data port) over m0 (fetch).
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic       vld0,
  input  logic       vld1,
  input  logic       last,
  output logic [1:0] grant
);

`ifdef RAM_ARB_RR_EN
  // Round-robin: on contention favour the master that was not granted last.
  always_comb begin
    grant = 2'b00;
    if (vld0 && vld1) begin
      grant = id_to_onehot(~last);
    end else if (vld1) begin
      grant = id_to_onehot(M1);
    end else if (vld0) begin
      grant = id_to_onehot(M0);
    end else begin
      grant = 2'b00;
    end
  end
`else
  logic unused_last_s;
  assign unused_last_s = last;

  // Fixed priority: the data port always wins over the fetch port.
  always_comb begin
    grant = 2'b00;
    if (vld1) begin
      grant = id_to_onehot(M1);
    end else if (vld0) begin
      grant = id_to_onehot(M0);
    end else begin
      grant = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/ram_arb.sv
// Two-master arbiter in front of a single-port RAM with combinational read.
// One transaction per three cycles: handshake, RAM access, response.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_vld,
  output logic          m0_req_rdy,
  input  logic [AW-1:0] m0_req_addr,
  input  logic          m0_req_we,
  input  logic [MW-1:0] m0_req_wem,
  input  logic [DW-1:0] m0_req_wdata,
  output logic          m0_rsp_vld,
  input  logic          m0_rsp_rdy,
  output logic [DW-1:0] m0_rsp_rdata,
  input  logic          m1_req_vld,
  output logic          m1_req_rdy,
  input  logic [AW-1:0] m1_req_addr,
  input  logic          m1_req_we,
  input  logic [MW-1:0] m1_req_wem,
  input  logic [DW-1:0] m1_req_wdata,
  output logic          m1_rsp_vld,
  input  logic          m1_rsp_rdy,
  output logic [DW-1:0] m1_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [MW-1:0] ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_e        state_r;
  logic          owner_r;
  logic          ram_cs_r;
  logic          ram_we_r;
  logic [MW-1:0] ram_wem_r;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_din_r;
  logic          m0_rsp_vld_r;
  logic          m1_rsp_vld_r;
  logic [DW-1:0] rsp_rdata_r;
  logic [1:0]    grant_s;
  logic          hs_s;
  logic          rsp_take_s;

  // The owner register doubles as the last-grant pointer for round-robin.
  ram_arb_pick u_pick (
    .vld0  (m0_req_vld),
    .vld1  (m1_req_vld),
    .last  (owner_r),
    .grant (grant_s)
  );

  // Request ready is only offered in IDLE and never during reset.
  always_comb begin
    m0_req_rdy = 1'b0;
    m1_req_rdy = 1'b0;
    if (!rst && (state_r == IDLE)) begin
      m0_req_rdy = grant_s[0];
      m1_req_rdy = grant_s[1];
    end else begin
      m0_req_rdy = 1'b0;
      m1_req_rdy = 1'b0;
    end
  end

  assign hs_s       = (m0_req_vld & m0_req_rdy) | (m1_req_vld & m1_req_rdy);
  assign rsp_take_s = (owner_r == M1) ? (m1_rsp_vld_r & m1_rsp_rdy)
                                      : (m0_rsp_vld_r & m0_rsp_rdy);

  // Transaction FSM; the RAM-side registers also serve as the command latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= M1;
      ram_cs_r     <= 1'b0;
      ram_we_r     <= 1'b0;
      ram_wem_r    <= {MW{1'b0}};
      ram_addr_r   <= {AW{1'b0}};
      ram_din_r    <= {DW{1'b0}};
      m0_rsp_vld_r <= 1'b0;
      m1_rsp_vld_r <= 1'b0;
      rsp_rdata_r  <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            state_r  <= ACCESS;
            ram_cs_r <= 1'b1;
            if (grant_s[1]) begin
              owner_r    <= M1;
              ram_we_r   <= m1_req_we;
              ram_wem_r  <= m1_req_wem;
              ram_addr_r <= m1_req_addr;
              ram_din_r  <= m1_req_wdata;
            end else begin
              owner_r    <= M0;
              ram_we_r   <= m0_req_we;
              ram_wem_r  <= m0_req_wem;
              ram_addr_r <= m0_req_addr;
              ram_din_r  <= m0_req_wdata;
            end
          end else begin
            state_r  <= IDLE;
            ram_cs_r <= 1'b0;
          end
        end
        ACCESS: begin
          state_r      <= RESP;
          ram_cs_r     <= 1'b0;
          rsp_rdata_r  <= ram_we_r ? {DW{1'b0}} : ram_dout;
          m0_rsp_vld_r <= (owner_r == M0);
          m1_rsp_vld_r <= (owner_r == M1);
        end
        RESP: begin
          if (rsp_take_s) begin
            state_r      <= IDLE;
            m0_rsp_vld_r <= 1'b0;
            m1_rsp_vld_r <= 1'b0;
            rsp_rdata_r  <= {DW{1'b0}};
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r      <= IDLE;
          ram_cs_r     <= 1'b0;
          m0_rsp_vld_r <= 1'b0;
          m1_rsp_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign ram_cs       = ram_cs_r;
  assign ram_we       = ram_we_r;
  assign ram_wem      = ram_wem_r;
  assign ram_addr     = ram_addr_r;
  assign ram_din      = ram_din_r;
  assign m0_rsp_vld   = m0_rsp_vld_r;
  assign m1_rsp_vld   = m1_rsp_vld_r;
  assign m0_rsp_rdata = rsp_rdata_r;
  assign m1_rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_ram_arb.sv
// Directed self-checking bench for ram_arb with a small behavioural RAM.
module tb_ram_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req_vld, m0_req_rdy, m0_req_we, m0_rsp_vld, m0_rsp_rdy;
  logic [AW-1:0] m0_req_addr;
  logic [MW-1:0] m0_req_wem;
  logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
  logic          m1_req_vld, m1_req_rdy, m1_req_we, m1_rsp_vld, m1_rsp_rdy;
  logic [AW-1:0] m1_req_addr;
  logic [MW-1:0] m1_req_wem;
  logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
  logic          ram_cs, ram_we;
  logic [MW-1:0] ram_wem;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic [DW-1:0] mem [0:15];
  logic          pre_we;
  logic [3:0]    pre_idx;
  logic [DW-1:0] pre_data;

  int checks = 0;
  int failures = 0;
  logic exp_m1;
  int seen;

  always #5 clk = ~clk;

  ram_arb #(.AW(AW), .DW(DW), .MW(MW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_addr(m0_req_addr),
    .m0_req_we(m0_req_we), .m0_req_wem(m0_req_wem), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_addr(m1_req_addr),
    .m1_req_we(m1_req_we), .m1_req_wem(m1_req_wem), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_rdata(m1_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  assign ram_dout = mem[ram_addr[5:2]];

  // Behavioural RAM: byte-masked write, plus a preload port for the bench.
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (ram_cs && ram_we)
      for (int b = 0; b < MW; b++)
        if (ram_wem[b]) mem[ram_addr[5:2]][8*b +: 8] <= ram_din[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pre_we = 1'b0; pre_idx = 4'd0; pre_data = 32'd0;
    m0_req_vld = 1'b0; m0_req_addr = 32'd0; m0_req_we = 1'b0; m0_req_wem = 4'd0;
    m0_req_wdata = 32'd0; m0_rsp_rdy = 1'b1;
    m1_req_vld = 1'b0; m1_req_addr = 32'd0; m1_req_we = 1'b0; m1_req_wem = 4'd0;
    m1_req_wdata = 32'd0; m1_rsp_rdy = 1'b1;
    tick();
    pre_we = 1'b1; pre_idx = 4'd4; pre_data = 32'hDEADBEEF;
    tick();
    pre_idx = 4'd8; pre_data = 32'hAABBCCDD;
    tick();
    pre_we = 1'b0;
    m0_req_vld = 1'b1;
    #1;
    chk("rst_req_rdy", {m0_req_rdy, m1_req_rdy}, 2'b00);
    chk("rst_outs", {ram_cs, ram_we, ram_wem, m0_rsp_vld, m1_rsp_vld}, 8'd0);
    chk("rst_addr_din", {ram_addr, ram_din, m0_rsp_rdata}, 96'd0);
    rst = 1'b0;

    // Single read by m0 at 0x10
    m0_req_addr = 32'h10; m0_req_we = 1'b0;
    #1;
    chk("rd_req_rdy", {m0_req_rdy, m1_req_rdy}, 2'b10);
    tick();
    m0_req_vld = 1'b0;
    #1;
    chk("rd_access", {ram_cs, ram_we, m0_req_rdy, m0_rsp_vld}, 4'b1000);
    chk("rd_addr", ram_addr, 32'h10);
    tick();
    chk("rd_rsp_vld", {m0_rsp_vld, m1_rsp_vld, ram_cs}, 3'b100);
    chk("rd_rdata", m0_rsp_rdata, 32'hDEADBEEF);
    tick();
    chk("rd_done", m0_rsp_vld, 1'b0);

    // Masked write by m1 at 0x20
    m1_req_vld = 1'b1; m1_req_addr = 32'h20; m1_req_we = 1'b1;
    m1_req_wem = 4'b0011; m1_req_wdata = 32'h11223344;
    #1;
    chk("wr_req_rdy", {m0_req_rdy, m1_req_rdy}, 2'b01);
    tick();
    m1_req_vld = 1'b0;
    #1;
    chk("wr_access", {ram_cs, ram_we, ram_wem}, 6'b110011);
    chk("wr_din", {ram_addr, ram_din}, {32'h20, 32'h11223344});
    tick();
    chk("wr_rsp", {m1_rsp_vld, m0_rsp_vld}, 2'b10);
    chk("wr_rdata", m1_rsp_rdata, 32'h0);
    tick();
    m0_req_vld = 1'b1; m0_req_addr = 32'h20;
    tick();
    m0_req_vld = 1'b0;
    tick();
    chk("wr_merge", {m0_rsp_vld, m0_rsp_rdata}, {1'b1, 32'hAABB3344});
    tick();

    // Contention: both masters request reads; last owner is m0
    m0_req_vld = 1'b1; m0_req_addr = 32'h10; m0_req_we = 1'b0;
    m1_req_vld = 1'b1; m1_req_addr = 32'h20; m1_req_we = 1'b0;
    for (int t = 0; t < 5; t++) begin
      if (t == 4) m1_req_vld = 1'b0;
`ifdef RAM_ARB_RR_EN
      exp_m1 = (t == 0 || t == 2);
`else
      exp_m1 = (t < 4);
`endif
      #1;
      chk($sformatf("cont_grant%0d", t), {m1_req_rdy, m0_req_rdy}, {exp_m1, ~exp_m1});
      tick();
      tick();
      chk($sformatf("cont_rsp%0d", t), {m1_rsp_vld, m0_rsp_vld, m0_rsp_rdata},
          {exp_m1, ~exp_m1, exp_m1 ? 32'hAABB3344 : 32'hDEADBEEF});
      if (t == 4) m0_req_vld = 1'b0;
      tick();
    end

    // Backpressure on m0 response while m1 is waiting
    m0_req_vld = 1'b1; m0_req_addr = 32'h10; m0_rsp_rdy = 1'b0;
    tick();
    m0_req_vld = 1'b0; m1_req_vld = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d", c),
          {m0_rsp_vld, m0_rsp_rdata, m0_req_rdy, m1_req_rdy, ram_cs},
          {1'b1, 32'hDEADBEEF, 3'b000});
      tick();
    end
    m0_rsp_rdy = 1'b1;
    tick();
    chk("bp_release", {m0_rsp_vld, m1_req_rdy}, 2'b01);
    tick();
    m1_req_vld = 1'b0;
    tick();
    chk("bp_waiter", {m1_rsp_vld, m1_rsp_rdata}, {1'b1, 32'hAABB3344});
    tick();

    // Reset during ACCESS aborts the transaction
    m0_req_vld = 1'b1; m0_req_addr = 32'h10;
    tick();
    m0_req_vld = 1'b0;
    chk("rm_access", ram_cs, 1'b1);
    rst = 1'b1;
    tick();
    chk("rm_outs", {ram_cs, ram_we, ram_wem, m0_rsp_vld, m1_rsp_vld, m0_req_rdy, m1_req_rdy},
        10'd0);
    chk("rm_data", {ram_addr, ram_din, m0_rsp_rdata}, 96'd0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (m0_rsp_vld) seen++;
      tick();
    end
    chk("rm_no_rsp", seen, 0);
    m0_req_vld = 1'b1; m0_req_addr = 32'h20;
    #1;
    chk("rm_new_rdy", m0_req_rdy, 1'b1);
    tick();
    m0_req_vld = 1'b0;
    tick();
    chk("rm_new_rsp", {m0_rsp_vld, m0_rsp_rdata}, {1'b1, 32'hAABB3344});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning the address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width in bits.
REQ-003 The block SHALL have parameter MW, default 4, meaning the width of the byte write mask.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, width 1: reset, synchronous, active-high.
REQ-006 The block SHALL have ports m0_req_vld / m1_req_vld, input, width 1: request valid.
REQ-007 The block SHALL have ports m0_req_rdy / m1_req_rdy, output, width 1: request accepted.
REQ-008 The block SHALL have ports m0_req_addr / m1_req_addr, input, width AW: byte address.
REQ-009 The block SHALL have ports m0_req_we / m1_req_we, input, width 1: 1 means write, 0 means read.
REQ-010 The block SHALL have ports m0_req_wem / m1_req_wem, input, width MW: byte write mask.
REQ-011 The block SHALL have ports m0_req_wdata / m1_req_wdata, input, width DW: write data.
REQ-012 The block SHALL have ports m0_rsp_vld / m1_rsp_vld, output, width 1: response valid.
REQ-013 The block SHALL have ports m0_rsp_rdy / m1_rsp_rdy, input, width 1: response taken.
REQ-014 The block SHALL have ports m0_rsp_rdata / m1_rsp_rdata, output, width DW: read data; 0 for writes.
REQ-015 The block SHALL have RAM-side outputs ram_cs (width 1), ram_we (width 1), ram_wem (width MW), ram_addr (width AW) and ram_din (width DW).
REQ-016 The block SHALL have RAM-side input ram_dout, width DW, which is the combinational read of the RAM at ram_addr.

Function
REQ-017 The FSM SHALL have three states, IDLE, ACCESS and RESP, with transitions:
- IDLE to ACCESS on a handshake (req_vld & req_rdy) by either master.
- ACCESS to RESP unconditionally.
- RESP to IDLE when rsp_vld & rsp_rdy for the owning master.
REQ-018 In IDLE, exactly one req_rdy SHALL be asserted, and only toward a requesting master; both req_rdy SHALL be 0 in ACCESS and RESP.
REQ-019 On handshake, the block SHALL latch addr, we, wem, wdata and the owner ID into command registers.
REQ-020 In ACCESS, the block SHALL drive ram_cs=1 and drive ram_we, ram_wem, ram_addr and ram_din from the command registers; ram_cs SHALL be 0 in every other state.
REQ-021 At the end of ACCESS, the block SHALL capture ram_dout into the response register for reads, and SHALL load 0 for writes.
REQ-022 In RESP, the owner's rsp_vld SHALL be 1 and the other master's rsp_vld SHALL be 0; rsp_rdata SHALL hold stable until rsp_rdy.
REQ-023 Latency SHALL be: handshake in cycle N, RAM access in N+1, rsp_vld first asserted in N+2; peak throughput is 1 transaction per 3 cycles.
REQ-024 A write with wem=0 SHALL still run the full sequence and return a response.
REQ-025 The block SHALL pass addresses through unmodified; word alignment is the responsibility of the RAM side.
REQ-026 A master SHALL hold its req_* fields stable while req_vld=1 and req_rdy=0; the arbiter is not required to tolerate violations.
REQ-027 A request that arrives while not in IDLE SHALL wait; no request SHALL be dropped.
REQ-028 rsp_rdy deasserted in RESP SHALL stall the block in RESP indefinitely, with both req_rdy held at 0.

Reset
REQ-029 While rst=1, the block SHALL hold state=IDLE, all req_rdy=0, rsp_vld=0, rsp_rdata=0, ram_cs=0, ram_we=0, ram_wem=0, ram_addr=0, ram_din=0, and the last-grant pointer at m1.
REQ-030 A reset asserted in ACCESS or RESP SHALL abort the transaction: no response is delivered, and the block resumes in IDLE in the first cycle after rst deasserts.

Configuration
REQ-031 With RAM_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests, grant goes to the master other than the last-granted one, and the pointer updates on each handshake.
REQ-032 Without RAM_ARB_RR_EN, arbitration SHALL be fixed priority with m1 (data port) over m0 (fetch port), and no pointer register SHALL exist.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the master ID constants (M0=1'b0, M1=1'b1).
REQ-034 The arbitration decision SHALL be a sub-module ram_arb_pick (inputs: two vld bits and the last-grant pointer; output: one-hot grant), with the macro affecting only this sub-module.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Single read: m0 read at addr 0x10 with RAM word 0xDEADBEEF -> ram_cs=1 at N+1, m0_rsp_vld=1 with rdata 0xDEADBEEF at N+2.
- Write with mask: m1 write addr 0x20, wdata 0x11223344, wem 4'b0011 -> ram_we=1 and ram_wem=4'b0011 at N+1; response rdata=0; a subsequent read returns the expected merge.
- Contention: m0 and m1 both valid for 4 transactions -> with RR_EN, grants alternate m1,m0,m1,m0; without it, all m1 first, then m0.
- Backpressure: m0_rsp_rdy=0 for 5 cycles in RESP -> rsp_vld and rdata stable, both req_rdy=0, ram_cs=0; completes the cycle after rsp_rdy=1.
- Reset mid-op: rst=1 during ACCESS -> next cycle all outputs are 0, no rsp_vld ever appears for that request, and a new request is accepted after reset.
